// File: rtl/dm_ext.sv
// MEM-stage data memory: byte/half/word stores with lane merge, extending loads,
// alignment checking, and a one-word-per-cycle clear sweep after reset.
module dm_ext #(
  parameter int ADDR_WIDTH     = 12,
  parameter bit CLEAR_ON_RESET = 1,
  parameter bit TRACE          = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        WE,
  input  logic        RE,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic        Busy,
  output logic        AlignErr
);
  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cnt, cnt_nxt;
  logic [31:0]   mem [DEPTH];

  logic [IW-1:0] idx;
  logic [31:0]   cur, merged, ext;
  logic          is_half, is_byte, is_sgn, wr_ok;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;

  assign idx     = Addr[ADDR_WIDTH-1:2];
  assign cur     = mem[idx];
  assign is_half = (Op == 3'b001) || (Op == 3'b010);
  assign is_byte = (Op == 3'b011) || (Op == 3'b100);
  assign is_sgn  = (Op == 3'b010) || (Op == 3'b100);
  assign Busy    = (state == CLEAR);

  // Reserved opcodes fall through to word accesses, including the alignment rule.
  always_comb begin
    AlignErr = 1'b0;
    if (RE || WE) begin
      if (is_half)       AlignErr = Addr[0];
      else if (!is_byte) AlignErr = |Addr[1:0];
    end
  end

  assign wr_ok = (state == IDLE) && !Reset && WE && !AlignErr;

  always_comb begin
    merged = WD;
    if (is_half) begin
      merged = cur;
      if (Addr[1]) merged[31:16] = WD[15:0];
      else         merged[15:0]  = WD[15:0];
    end else if (is_byte) begin
      merged = cur;
      case (Addr[1:0])
        2'd0:    merged[7:0]   = WD[7:0];
        2'd1:    merged[15:8]  = WD[7:0];
        2'd2:    merged[23:16] = WD[7:0];
        default: merged[31:24] = WD[7:0];
      endcase
    end
  end

  always_comb begin
    half_sel = Addr[1] ? cur[31:16] : cur[15:0];
    case (Addr[1:0])
      2'd0:    byte_sel = cur[7:0];
      2'd1:    byte_sel = cur[15:8];
      2'd2:    byte_sel = cur[23:16];
      default: byte_sel = cur[31:24];
    endcase
    ext = cur;
    if (is_half)      ext = {{16{is_sgn & half_sel[15]}}, half_sel};
    else if (is_byte) ext = {{24{is_sgn & byte_sel[7]}}, byte_sel};
    RD = (Busy || !RE || AlignErr) ? 32'd0 : ext;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == IW'(DEPTH - 1)) state_nxt = IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (state == CLEAR && !Reset) begin
      mem[cnt] <= 32'd0;
    end else if (wr_ok) begin
      mem[idx] <= merged;
      if (TRACE) $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, merged);
    end
  end
endmodule

// File: doc/dm_ext.md
Name: dm_ext

Overview:
- Parametrised data memory for the single-cycle/pipelined MIPS datapath; successor to the word-only data memory.
- Adds byte/halfword stores with byte-lane merge, sign/zero-extending sub-word loads, alignment checking, and a sequential clear engine.
- The clear engine sweeps memory after reset instead of clearing every word in one cycle.
- Sits in the MEM stage; ALU result drives Addr, rt value drives WD, and RD goes to the writeback mux.

Parameters:
- ADDR_WIDTH, 12: number of byte-address bits decoded. Word index = Addr[ADDR_WIDTH-1:2]; DEPTH = 2^(ADDR_WIDTH-2) words.
- CLEAR_ON_RESET, 1: 1 = reset starts the clear sweep; 0 = reset only returns the FSM to IDLE and leaves contents as they are.
- TRACE, 1: 1 = emit the write-trace $display on every committed write.

Ports:
- Clk, input, 1: clock; all state updates on the rising edge.
- Reset, input, 1: synchronous, active-high reset.
- WE, input, 1: write enable.
- RE, input, 1: read enable.
- Op, input, 3: access type. 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101–111 reserved, treated as word.
- Addr, input, 32: byte address; bits above ADDR_WIDTH-1 are ignored.
- WD, input, 32: store data, right-aligned (byte in WD[7:0], half in WD[15:0]).
- PC, input, 32: PC of the accessing instruction; used for the trace only.
- RD, output, 32: load data, extended per Op.
- Busy, output, 1: 1 while the clear sweep runs.
- AlignErr, output, 1: combinational misalignment flag for the current access.

Behaviour:
- FSM states: IDLE, CLEAR.
- Reset=1 at a rising edge:
  - CLEAR_ON_RESET=1: go to CLEAR, clear counter ← 0.
  - CLEAR_ON_RESET=0: go to IDLE.
  - Applies equally when Reset arrives mid-sweep: the counter restarts at 0.
- CLEAR state:
  - Each cycle writes mem[counter] ← 0, then counter increments.
  - The write at counter = DEPTH-1 is the last; the next state is IDLE.
  - Sweep takes exactly DEPTH cycles after Reset deasserts; the counter is ADDR_WIDTH-2 bits.
  - Busy=1 for the whole sweep; Busy=0 in IDLE.
- Register reset values: Busy=1 after reset when CLEAR_ON_RESET=1, else 0. RD and AlignErr are combinational and reset-free, but RD=0 while Busy.
- During CLEAR: WE is ignored (no write, no trace) and RD=0. The CPU is expected to stall on Busy.
- Alignment:
  - AlignErr=1 when (RE|WE) and: a word access has Addr[1:0]≠00, or a half access has Addr[0]≠0.
  - Byte accesses never fault. AlignErr=0 when RE=WE=0.
- Writes (IDLE, WE=1, AlignErr=0), committed on the rising edge. Lane = Addr[1:0] little-endian (lane 0 = bits 7:0).
  - Word: mem[idx] ← WD.
  - Half: Addr[1]=0 → bits 15:0 ← WD[15:0]; Addr[1]=1 → bits 31:16 ← WD[15:0]. The other half is preserved.
  - Byte: lane bits ← WD[7:0]; the other three bytes are preserved.
  - A misaligned write is suppressed: memory unchanged, no trace.
- Reads (combinational from mem[idx]):
  - RE=0 → RD=0.
  - Half/byte: select the lane by Addr, then zero- or sign-extend per Op.
  - Misaligned read → RD=0.
  - Read and write to the same word in one cycle: RD shows the old contents; the new contents are visible after the edge.
- Trace (TRACE=1): format is "@%h: *%h <= %h" with PC, Addr with [1:0] forced to 00, and the full merged 32-bit word after the write.

Test Plan:
- Clear sweep, ADDR_WIDTH=6: preload mem[3]=32'hDEADBEEF; pulse Reset 1 cycle → Busy high exactly 16 cycles; afterwards word read @0xC returns 0.
- Reset mid-sweep: at counter=5, assert Reset 1 cycle → counter restarts at 0; Busy lasts a further 16 cycles; a write attempted during the sweep has no effect.
- Store half: sw 0x11223344 @0x10, then sh WD=0xAAAA5566 @0x12 → word reads 0x55663344; trace prints "*00000010 <= 55663344".
- Store byte: sb WD=0x000000F0 @0x13 on that word → 0xF0663344. lb @0x13 = 0xFFFFFFF0; lbu = 0x000000F0; lh @0x12 = 0xFFFFF066; lhu = 0x0000F066.
- Misaligned access: sw @0x22 → AlignErr=1, mem unchanged, no trace. lh @0x11 → AlignErr=1, RD=0. lb @0x11 → AlignErr=0.
- Read gating and same-cycle read/write: RE=0 gives RD=0 regardless of contents. A read of a word being written in the same cycle returns the old value; the next cycle returns the new value.
